// File: rtl/i2s_bram_capture_dma.sv
// Captures a clip of 16-bit audio samples into PS-shared BRAM, one word per clock.
// Define I2S_CAPTURE_PACK_SAMPLES_EN to pack two samples per 32-bit word.
module i2s_bram_capture_dma #(
  parameter int unsigned NUM_WORDS  = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] BRAM_addr,
  output logic        BRAM_clk,
  output logic [31:0] BRAM_din,
  input  logic [31:0] BRAM_dout,
  output logic        BRAM_en,
  output logic        BRAM_rst,
  output logic [3:0]  BRAM_we,
  input  logic        start,
  input  logic        pause,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [15:0] words_written
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
`ifdef I2S_CAPTURE_PACK_SAMPLES_EN
  localparam int unsigned TOTAL_SAMPLES = 2 * NUM_WORDS;
`else
  localparam int unsigned TOTAL_SAMPLES = NUM_WORDS;
`endif
  localparam logic [16:0]      TOTAL_C = 17'(TOTAL_SAMPLES);
  localparam logic [15:0]      WORDS_C = 16'(NUM_WORDS);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [16:0]      acc_cnt_q, acc_cnt_d;
  logic [15:0]      words_q, words_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             bram_en_q, bram_en_d;
  logic [3:0]       bram_we_q, bram_we_d;
  logic [31:0]      bram_din_q, bram_din_d;
  logic [31:0]      bram_addr_q, bram_addr_d;
  logic             bram_rst_q, bram_rst_d;
`ifdef I2S_CAPTURE_PACK_SAMPLES_EN
  logic [15:0]      low_q, low_d;
  logic             half_q, half_d;
`endif

  logic        in_capture;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic [15:0] head;
  logic        issue;
  logic [31:0] word_data;
  logic        unused_dout;

  // Read data port exists only so the block drops into the playback wiring.
  assign unused_dout = ^BRAM_dout;

  // Valid/ready: a sample transfers on any rising edge where both are high.
  // sample_ready depends on registered state only, never on sample_valid.
  assign in_capture   = (state_q == ST_CAPTURE);
  assign fifo_full    = (fifo_cnt_q == DEPTH_C);
  assign fifo_empty   = (fifo_cnt_q == '0);
  assign sample_ready = in_capture && !fifo_full && (acc_cnt_q < TOTAL_C);
  assign push         = sample_valid && sample_ready;
  assign pop          = in_capture && !fifo_empty && !pause;
  assign head         = fifo_mem_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_cnt_d  = fifo_cnt_q;
    acc_cnt_d   = acc_cnt_q;
    words_d     = words_q;
    busy_d      = busy_q;
    done_d      = done_q;
    ovf_d       = ovf_q;
    bram_en_d   = 1'b0;
    bram_we_d   = 4'h0;
    bram_din_d  = bram_din_q;
    bram_addr_d = bram_addr_q;
    bram_rst_d  = 1'b0;
    issue       = 1'b0;
    word_data   = 32'h0;
`ifdef I2S_CAPTURE_PACK_SAMPLES_EN
    low_d       = low_q;
    half_d      = half_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_CAPTURE;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          ovf_d      = 1'b0;
          words_d    = 16'h0;
          acc_cnt_d  = 17'h0;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          fifo_cnt_d = '0;
`ifdef I2S_CAPTURE_PACK_SAMPLES_EN
          half_d     = 1'b0;
`endif
        end
      end
      ST_CAPTURE: begin
        if (sample_valid && fifo_full) begin
          ovf_d = 1'b1;
        end
        if (push) begin
          wr_ptr_d  = wr_ptr_q + 1'b1;
          acc_cnt_d = acc_cnt_q + 17'd1;
        end
        if (pop) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
`ifdef I2S_CAPTURE_PACK_SAMPLES_EN
          if (!half_q) begin
            low_d  = head;
            half_d = 1'b1;
          end else begin
            half_d    = 1'b0;
            issue     = 1'b1;
            word_data = {head, low_q};
          end
`else
          issue     = 1'b1;
          word_data = {{16{head[15]}}, head};
`endif
        end
        case ({push, pop})
          2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
          2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
          default: fifo_cnt_d = fifo_cnt_q;
        endcase
        if (words_q == WORDS_C && fifo_empty) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // The count guard keeps the address inside the clip window.
    if (issue && words_q != WORDS_C) begin
      bram_en_d   = 1'b1;
      bram_we_d   = 4'hF;
      bram_din_d  = word_data;
      bram_addr_d = BASE_ADDR + {14'h0, words_q, 2'b00};
      words_d     = words_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      acc_cnt_q   <= 17'h0;
      words_q     <= 16'h0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      bram_en_q   <= 1'b0;
      bram_we_q   <= 4'h0;
      bram_din_q  <= 32'h0;
      bram_addr_q <= BASE_ADDR;
      bram_rst_q  <= 1'b1;
`ifdef I2S_CAPTURE_PACK_SAMPLES_EN
      low_q       <= 16'h0;
      half_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      acc_cnt_q   <= acc_cnt_d;
      words_q     <= words_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      bram_en_q   <= bram_en_d;
      bram_we_q   <= bram_we_d;
      bram_din_q  <= bram_din_d;
      bram_addr_q <= bram_addr_d;
      bram_rst_q  <= bram_rst_d;
`ifdef I2S_CAPTURE_PACK_SAMPLES_EN
      low_q       <= low_d;
      half_q      <= half_d;
`endif
    end
  end

  // Sample storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= sample_in;
    end
  end

  assign BRAM_clk      = clk;
  assign BRAM_addr     = bram_addr_q;
  assign BRAM_din      = bram_din_q;
  assign BRAM_en       = bram_en_q;
  assign BRAM_we       = bram_we_q;
  assign BRAM_rst      = bram_rst_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign overflow      = ovf_q;
  assign words_written = words_q;

endmodule

// File: tb/tb_i2s_bram_capture_dma.sv
// Randomized scoreboard bench for i2s_bram_capture_dma; the model predicts each BRAM write.
`timescale 1ns/1ps
module tb_i2s_bram_capture_dma;

  localparam int          NUM_WORDS  = 256;
  localparam logic [31:0] BASE_ADDR  = 32'h0000_0400;
  localparam int          FIFO_DEPTH = 4;
`ifdef I2S_CAPTURE_PACK_SAMPLES_EN
  localparam int SPW = 2;
`else
  localparam int SPW = 1;
`endif
  localparam int TOTAL = NUM_WORDS * SPW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] BRAM_addr;
  logic        BRAM_clk;
  logic [31:0] BRAM_din;
  logic [31:0] BRAM_dout = 32'h0;
  logic        BRAM_en;
  logic        BRAM_rst;
  logic [3:0]  BRAM_we;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [15:0] sample_in = 16'h0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] words_written;

  i2s_bram_capture_dma #(
    .NUM_WORDS (NUM_WORDS),
    .BASE_ADDR (BASE_ADDR),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .BRAM_addr    (BRAM_addr),
    .BRAM_clk     (BRAM_clk),
    .BRAM_din     (BRAM_din),
    .BRAM_dout    (BRAM_dout),
    .BRAM_en      (BRAM_en),
    .BRAM_rst     (BRAM_rst),
    .BRAM_we      (BRAM_we),
    .start        (start),
    .pause        (pause),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow),
    .words_written(words_written)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [63:0] exp_q[$];
  logic [15:0] stim_q[$];
  logic [31:0] mem [0:NUM_WORDS-1];
  int          checks = 0;
  int          errors = 0;
  int          m_idx = 0;
  logic        m_half = 1'b0;
  logic [15:0] m_low = 16'h0;
  int          wr_count = 0;
  int          first_acc_edge = -1;
  int          first_wr_cyc = -1;
  int          last_wr_cyc = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_idx  = 0;
    m_half = 1'b0;
  endtask

  // Reference: the n-th word of a clip lands at BASE+4n, one sample (sign-extended)
  // or two samples (first low, second high) per word.
  task automatic model_accept(input logic [15:0] s);
    logic [31:0] w;
    if (first_acc_edge < 0) first_acc_edge = cyc + 1;
    if (SPW == 1) begin
      w = {{16{s[15]}}, s};
      exp_q.push_back({BASE_ADDR + 32'(4 * m_idx), w});
      m_idx++;
    end else if (!m_half) begin
      m_low  = s;
      m_half = 1'b1;
    end else begin
      w = {s, m_low};
      exp_q.push_back({BASE_ADDR + 32'(4 * m_idx), w});
      m_idx++;
      m_half = 1'b0;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [63:0] e;
    logic [31:0] off;
    if (!rst && BRAM_en === 1'b1) begin
      wr_count++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0h din=%0h", BRAM_addr, BRAM_din);
      end else begin
        e = exp_q.pop_front();
        if ({BRAM_addr, BRAM_din} !== e || BRAM_we !== 4'hF) begin
          errors++;
          $display("FAIL bram_write actual addr=%0h din=%0h we=%0h expected addr=%0h din=%0h we=f",
                   BRAM_addr, BRAM_din, BRAM_we, e[63:32], e[31:0]);
        end
      end
      off = (BRAM_addr - BASE_ADDR) >> 2;
      if (off < 32'(NUM_WORDS)) mem[off] = BRAM_din;
    end
  end

  // ---------------- driver tasks (entered and left on a negedge) ----------------
  task automatic send_sample(input logic [15:0] s);
    int  waited = 0;
    bit  acc = 0;
    sample_in    = s;
    sample_valid = 1'b1;
    while (!acc) begin
      #1;
      if (sample_ready === 1'b1) begin
        acc = 1;
        model_accept(s);
      end
      @(negedge clk);
      if (!acc) begin
        waited++;
        if (waited > 200) begin
          check("ready_timeout", 64'(sample_ready), 64'd1);
          break;
        end
      end
    end
  endtask

  task automatic drive_stim(input int max_gap);
    int g;
    while (stim_q.size() > 0) begin
      send_sample(stim_q.pop_front());
      g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      if (g > 0) begin
        sample_valid = 1'b0;
        repeat (g) @(negedge clk);
      end
    end
    sample_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (done !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", 64'(done), 64'd1);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_addr", 64'(BRAM_addr), 64'(BASE_ADDR));
    check("rst_din", 64'(BRAM_din), 64'd0);
    check("rst_en", 64'(BRAM_en), 64'd0);
    check("rst_we", 64'(BRAM_we), 64'd0);
    check("rst_bram_rst", 64'(BRAM_rst), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_words", 64'(words_written), 64'd0);
    check("rst_ready", 64'(sample_ready), 64'd0);
    @(negedge clk);
    check("bram_rst_release", 64'(BRAM_rst), 64'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] addr_before;
    logic [15:0] pv [6];
    int          k;
    int          wr_before;

    repeat (3) @(negedge clk);
    do_reset();
    check("bram_clk_follows", 64'(BRAM_clk), 64'(clk));

    // Sequential clip 0..TOTAL-1 at full rate.
    pulse_start();
    check("start_busy", 64'(busy), 64'd1);
    for (int i = 0; i < TOTAL; i++) stim_q.push_back(16'(i));
    drive_stim(0);
    wait_done(TOTAL * 4 + 50);
    check("seq_busy", 64'(busy), 64'd0);
    check("seq_words", 64'(words_written), 64'(NUM_WORDS));
    check("seq_overflow", 64'(overflow), 64'd0);
    check("seq_en_idle", 64'(BRAM_en), 64'd0);
    check("seq_drained", 64'(exp_q.size()), 64'd0);
    check("seq_latency", 64'(first_wr_cyc - first_acc_edge), 64'(SPW));
    check("seq_throughput", 64'(last_wr_cyc - first_wr_cyc), 64'(SPW * (NUM_WORDS - 1)));
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (SPW == 1) check("seq_mem", 64'(mem[i]), 64'(i));
      else check("seq_mem", 64'(mem[i]), 64'({16'(2 * i + 1), 16'(2 * i)}));
    end

    // Start from DONE, random stream with gaps, start ignored mid-capture.
    model_reset();
    pulse_start();
    check("restart_done_clear", 64'(done), 64'd0);
    check("restart_words", 64'(words_written), 64'd0);
    check("restart_busy", 64'(busy), 64'd1);
`ifdef I2S_CAPTURE_PACK_SAMPLES_EN
    stim_q.push_back(16'h1111);
    stim_q.push_back(16'h2222);
`endif
    stim_q.push_back(16'h8001);
    stim_q.push_back(16'h7FFF);
    while (stim_q.size() < 50) stim_q.push_back(16'($urandom));
    drive_stim(2);
    repeat (6) @(negedge clk);
    addr_before = BRAM_addr;
    check("mid_words", 64'(words_written), 64'(m_idx));
    pulse_start();
    @(negedge clk);
    check("mid_start_words", 64'(words_written), 64'(m_idx));
    check("mid_start_addr", 64'(BRAM_addr), 64'(addr_before));
    check("mid_start_busy", 64'(busy), 64'd1);
    for (int i = 50; i < TOTAL; i++) stim_q.push_back(16'($urandom));
    drive_stim(2);
    wait_done(TOTAL * 6 + 50);
    check("rand_words", 64'(words_written), 64'(NUM_WORDS));
    check("rand_overflow", 64'(overflow), 64'd0);
`ifdef I2S_CAPTURE_PACK_SAMPLES_EN
    check("pack_word0", 64'(mem[0]), 64'h2222_1111);
    check("pack_word1", 64'(mem[1]), 64'h7FFF_8001);
`else
    check("sext_neg", 64'(mem[0]), 64'hFFFF_8001);
    check("sext_pos", 64'(mem[1]), 64'h0000_7FFF);
`endif

    // Pause: FIFO fills, overflow flags, nothing is written until released.
    model_reset();
    pulse_start();
    pause = 1'b1;
    for (int i = 0; i < 6; i++) pv[i] = 16'($urandom);
    k = 0;
    wr_before = wr_count;
    for (int c = 0; c < 10; c++) begin
      sample_in    = pv[(k < 6) ? k : 5];
      sample_valid = (k < 6);
      #1;
      if (sample_valid && sample_ready === 1'b1) begin
        model_accept(pv[k]);
        k++;
      end
      @(negedge clk);
    end
    check("pause_accepted", 64'(k), 64'(FIFO_DEPTH));
    check("pause_ready_low", 64'(sample_ready), 64'd0);
    check("pause_overflow", 64'(overflow), 64'd1);
    check("pause_no_write", 64'(wr_count - wr_before), 64'd0);
    check("pause_we_low", 64'(BRAM_we), 64'd0);
    sample_valid = 1'b0;
    pause = 1'b0;
    repeat (8) @(negedge clk);
    check("pause_drained", 64'(exp_q.size()), 64'd0);
    check("pause_words", 64'(words_written), 64'(FIFO_DEPTH / SPW));
    for (int i = FIFO_DEPTH; i < TOTAL; i++) stim_q.push_back(16'($urandom));
    drive_stim(1);
    wait_done(TOTAL * 4 + 50);
    check("pause_overflow_sticky", 64'(overflow), 64'd1);

    // Reset mid-capture, then a fresh clip from BASE_ADDR.
    model_reset();
    pulse_start();
    check("start_clears_overflow", 64'(overflow), 64'd0);
    for (int i = 0; i < 100 * SPW; i++) stim_q.push_back(16'($urandom));
    drive_stim(0);
    do_reset();
    first_wr_cyc = -1;
    pulse_start();
    for (int i = 0; i < TOTAL; i++) stim_q.push_back(16'($urandom));
    drive_stim(1);
    wait_done(TOTAL * 4 + 50);
    check("post_rst_words", 64'(words_written), 64'(NUM_WORDS));
    check("post_rst_busy", 64'(busy), 64'd0);

    repeat (4) @(negedge clk);
    check("final_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
